bin2bcd_seq: RTL

//   Sequential binary-to-BCD converter (shift-and-add-3) sitting downstream of the
//   8x8 operand-register multiplier. It consumes the 16-bit product and produces
//   5 decimal digits for the seven-segment decoders, so the product shows in decimal

---
 rtl/bin2bcd_seq.sv | 92 +++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with a start/busy/done handshake.
// One conversion takes IN_W cycles; the result is held on bcd until the next conversion completes.
module bin2bcd_seq #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5,
    parameter int CW     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [IN_W-1:0]       shift_q, shift_d;
    logic [4*DIGITS-1:0]   scratch_q, scratch_d;
    logic [4*DIGITS-1:0]   adj;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  done_q, done_d;

    // Digits >= 5 get +3 before the shift so they carry correctly into the next digit.
    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] s);
        logic [4*DIGITS-1:0] r;
        r = s;
        for (int k = 0; k < DIGITS; k++) begin
            if (s[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = s[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        adj       = add3(scratch_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(IN_W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[4*DIGITS-2:0], shift_q[IN_W-1]};
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d   = scratch_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule
